// File: rtl/xge_rx.sv
// Shared RX-path types: packet descriptor, direction codes, class/error bit indices.
package xge_rx;

    typedef logic [1:0] rx_dir_t;

    localparam rx_dir_t RX_DIR_DROP = 2'd0;
    localparam rx_dir_t RX_DIR_CPU  = 2'd1;
    localparam rx_dir_t RX_DIR_CNT  = 2'd2;

    localparam int CPU_CLS_OAM       = 0;
    localparam int CPU_CLS_TELNET    = 1;
    localparam int CPU_CLS_SSH       = 2;
    localparam int CPU_CLS_ARP       = 3;
    localparam int CPU_CLS_ICMP      = 4;
    localparam int CPU_CLS_DHCP      = 5;
    localparam int CPU_CLS_DNS       = 6;
    localparam int CPU_CLS_PTP       = 7;
    localparam int CPU_CLS_TWAMP_CTL = 8;
    localparam int CPU_CLS_USERCAST  = 9;
    localparam int CPU_CLS_NIC_ENCAP = 10;
    localparam int CPU_CLS_NUM       = 11;

    localparam int DROP_ERR_CRC      = 0;
    localparam int DROP_ERR_RUNT     = 1;
    localparam int DROP_ERR_OVERSIZE = 2;
    localparam int DROP_ERR_NUM      = 3;

    typedef struct packed {
        logic [15:0]            pkt_size;
        logic [CPU_CLS_NUM-1:0] cls;
        logic                   oversize;
        logic                   runt;
        logic                   crc_err;
    } pkt_rx_info_t;

endpackage

// File: rtl/xge_rx_cpu_policer.sv
// Byte token bucket for CPU-bound packets: grant when tokens cover the size, refill on tick.
module xge_rx_cpu_policer #(
    parameter int TOKEN_W = 20
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               tick_i,
    input  logic [TOKEN_W-1:0] rate_i,
    input  logic [TOKEN_W-1:0] max_i,
    input  logic               req_i,
    input  logic [15:0]        size_i,
    output logic               grant_o
);
    logic [TOKEN_W-1:0] r_tokens;
    logic [TOKEN_W-1:0] w_size;
    logic [TOKEN_W-1:0] w_left;
    logic [TOKEN_W:0]   w_sum;
    logic [TOKEN_W-1:0] w_tokens_nxt;

    assign w_size  = TOKEN_W'(size_i);
    assign grant_o = req_i && (r_tokens >= w_size);
    assign w_left  = r_tokens - (grant_o ? w_size : '0);
    // One extra bit so a large rate cannot wrap before the ceiling clamp.
    assign w_sum   = {1'b0, w_left} + {1'b0, rate_i};

    always_comb begin
        w_tokens_nxt = w_left;
        if (tick_i)
            w_tokens_nxt = (w_sum > {1'b0, max_i}) ? max_i : w_sum[TOKEN_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_tokens <= '0;
        else          r_tokens <= w_tokens_nxt;
    end

endmodule

// File: rtl/xge_rx_sync_fifo.sv
// Common single-clock FIFO; power-of-two depth, occupancy count exported for flow control.
module xge_rx_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en_i) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (rd_en_i) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(wr_en_i) - CW'(rd_en_i);
        end
    end

    // Storage needs no reset: contents are only observed under a non-zero count.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) r_mem[r_wr_ptr] <= wr_data_i;
    end

    assign rd_data_o = r_mem[r_rd_ptr];
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;

endmodule

// File: rtl/xge_rx_dir_arb.sv
// RX direction scheduler: classify -> police -> decision FIFO towards traf_engine.
// Statistics counters are built only when XGE_RX_DIR_STATS_EN is defined.
module xge_rx_dir_arb
    import xge_rx::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TOKEN_W    = 20
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  pkt_rx_info_t           info_i,
    input  logic                   info_valid_i,
    output logic                   info_ready_o,
    input  logic [CPU_CLS_NUM-1:0] cpu_class_en_i,
    input  logic [DROP_ERR_NUM-1:0] drop_err_en_i,
    input  logic                   cnt_en_i,
    input  logic                   cpu_tick_i,
    input  logic [TOKEN_W-1:0]     cpu_rate_i,
    input  logic [TOKEN_W-1:0]     cpu_bucket_max_i,
    output logic [1:0]             dir_o,
    output logic [15:0]            dir_pkt_size_o,
    output logic                   dir_valid_o,
    input  logic                   dir_ready_i,
    input  logic                   stat_clr_i,
    output logic [31:0]            cpu_policed_cnt_o,
    output logic [31:0]            drop_cnt_o
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int USED_W = CNT_W + 1;

    logic                    r_s1_vld, r_s2_vld, r_ready;
    rx_dir_t                 r_s1_dir, r_s2_dir;
    logic [15:0]             r_s1_size, r_s2_size;
    logic                    w_accept, w_err, w_trap, w_req, w_grant, w_pop, w_empty;
    logic [DROP_ERR_NUM-1:0] w_err_vec;
    rx_dir_t                 w_s1_dir, w_s2_dir;
    logic [CNT_W-1:0]        w_count;
    logic [USED_W-1:0]       w_used_nxt;
    logic [17:0]             w_head;

    assign w_accept = info_valid_i && r_ready;

    always_comb begin
        w_err_vec                    = '0;
        w_err_vec[DROP_ERR_CRC]      = info_i.crc_err;
        w_err_vec[DROP_ERR_RUNT]     = info_i.runt;
        w_err_vec[DROP_ERR_OVERSIZE] = info_i.oversize;
    end

    assign w_err  = |(drop_err_en_i & w_err_vec);
    assign w_trap = |(cpu_class_en_i & info_i.cls);

    always_comb begin
        w_s1_dir = RX_DIR_DROP;
        if (!w_err) begin
            if (w_trap)        w_s1_dir = RX_DIR_CPU;
            else if (cnt_en_i) w_s1_dir = RX_DIR_CNT;
        end
    end

    assign w_req    = r_s1_vld && (r_s1_dir == RX_DIR_CPU);
    assign w_s2_dir = (w_req && !w_grant) ? RX_DIR_DROP : r_s1_dir;

    xge_rx_cpu_policer #(.TOKEN_W(TOKEN_W)) u_policer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .tick_i  (cpu_tick_i),
        .rate_i  (cpu_rate_i),
        .max_i   (cpu_bucket_max_i),
        .req_i   (w_req),
        .size_i  (r_s1_size),
        .grant_o (w_grant)
    );

    // Next-cycle FIFO fill plus in-flight pipeline entries; ready only while a slot stays reserved.
    assign w_used_nxt = USED_W'(w_count) + USED_W'(r_s2_vld) + USED_W'(r_s1_vld)
                      + USED_W'(w_accept) - USED_W'(w_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s1_dir  <= RX_DIR_DROP;
            r_s2_dir  <= RX_DIR_DROP;
            r_s1_size <= '0;
            r_s2_size <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            r_s2_vld <= r_s1_vld;
            if (w_accept) begin
                r_s1_dir  <= w_s1_dir;
                r_s1_size <= info_i.pkt_size;
            end
            if (r_s1_vld) begin
                r_s2_dir  <= w_s2_dir;
                r_s2_size <= r_s1_size;
            end
            r_ready <= (w_used_nxt < USED_W'(FIFO_DEPTH));
        end
    end

    assign w_pop = !w_empty && dir_ready_i;

    xge_rx_sync_fifo #(.WIDTH(18), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (r_s2_vld),
        .wr_data_i ({r_s2_dir, r_s2_size}),
        .rd_en_i   (w_pop),
        .rd_data_o (w_head),
        .empty_o   (w_empty),
        .count_o   (w_count)
    );

    assign info_ready_o   = r_ready;
    assign dir_valid_o    = !w_empty;
    assign dir_o          = w_empty ? RX_DIR_DROP : w_head[17:16];
    assign dir_pkt_size_o = w_empty ? 16'd0 : w_head[15:0];

`ifdef XGE_RX_DIR_STATS_EN
    logic [31:0] r_policed_cnt, r_drop_cnt;
    logic        w_policed, w_drop_dec;

    assign w_policed  = w_req && !w_grant;
    assign w_drop_dec = r_s1_vld && (w_s2_dir == RX_DIR_DROP);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || stat_clr_i) begin
            r_policed_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_policed)  r_policed_cnt <= r_policed_cnt + 32'd1;
            if (w_drop_dec) r_drop_cnt    <= r_drop_cnt + 32'd1;
        end
    end

    assign cpu_policed_cnt_o = r_policed_cnt;
    assign drop_cnt_o        = r_drop_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr      = stat_clr_i;
    assign cpu_policed_cnt_o = 32'd0;
    assign drop_cnt_o        = 32'd0;
`endif

endmodule

// File: tb/tb_xge_rx_dir_arb.sv
// Directed bench for xge_rx_dir_arb; counter expectations follow XGE_RX_DIR_STATS_EN.
module tb_xge_rx_dir_arb;
    import xge_rx::*;

`ifdef XGE_RX_DIR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    pkt_rx_info_t  info_i;
    logic          info_valid_i, info_ready_o;
    logic [10:0]   cpu_class_en_i;
    logic [2:0]    drop_err_en_i;
    logic          cnt_en_i, cpu_tick_i;
    logic [19:0]   cpu_rate_i, cpu_bucket_max_i;
    logic [1:0]    dir_o;
    logic [15:0]   dir_pkt_size_o;
    logic          dir_valid_o, dir_ready_i, stat_clr_i;
    logic [31:0]   cpu_policed_cnt_o, drop_cnt_o;

    int checks   = 0;
    int failures = 0;
    logic [17:0] got [$];

    xge_rx_dir_arb #(.FIFO_DEPTH(8), .TOKEN_W(20)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .info_i(info_i), .info_valid_i(info_valid_i),
        .info_ready_o(info_ready_o), .cpu_class_en_i(cpu_class_en_i), .drop_err_en_i(drop_err_en_i),
        .cnt_en_i(cnt_en_i), .cpu_tick_i(cpu_tick_i), .cpu_rate_i(cpu_rate_i),
        .cpu_bucket_max_i(cpu_bucket_max_i), .dir_o(dir_o), .dir_pkt_size_o(dir_pkt_size_o),
        .dir_valid_o(dir_valid_o), .dir_ready_i(dir_ready_i), .stat_clr_i(stat_clr_i),
        .cpu_policed_cnt_o(cpu_policed_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Pops happen on the following rising edge; inputs are stable at the falling edge.
    always @(negedge clk_i)
        if (dir_valid_o && dir_ready_i) got.push_back({dir_o, dir_pkt_size_o});

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic send(input logic [15:0] sz, input logic [10:0] cls, input logic [2:0] err);
        int n = 0;
        while (!info_ready_o && n < 50) begin step(); n++; end
        info_i = '0;
        info_i.pkt_size = sz;
        info_i.cls = cls;
        {info_i.oversize, info_i.runt, info_i.crc_err} = err;
        info_valid_i = 1'b1;
        step();
        info_valid_i = 1'b0;
    endtask

    task automatic wait_q(input int n, input string tag);
        int k = 0;
        while (got.size() < n && k < 100) begin step(); k++; end
        check(tag, 32'(got.size()), 32'(n));
    endtask

    task automatic check_entry(input int idx, input rx_dir_t d, input logic [15:0] sz, input string tag);
        logic [17:0] e;
        e = (idx < got.size()) ? got[idx] : 18'h3ffff;
        check(tag, 32'(e), 32'({d, sz}));
    endtask

    task automatic tick_once();
        cpu_tick_i = 1'b1;
        step();
        cpu_tick_i = 1'b0;
    endtask

    localparam logic [10:0] ARP = 11'(1) << CPU_CLS_ARP;

    initial begin
        int sent, acc;
        rst_n_i = 1'b0; info_i = '0; info_valid_i = 1'b0;
        cpu_class_en_i = '0; drop_err_en_i = '0; cnt_en_i = 1'b0; cpu_tick_i = 1'b0;
        cpu_rate_i = '0; cpu_bucket_max_i = '0; dir_ready_i = 1'b1; stat_clr_i = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_valid", 32'(dir_valid_o), 32'd0);
        check("rst_ready", 32'(info_ready_o), 32'd0);
        check("rst_dir", 32'(dir_o), 32'd0);
        check("rst_size", 32'(dir_pkt_size_o), 32'd0);
        check("rst_pol", cpu_policed_cnt_o, 32'd0);
        check("rst_drop", drop_cnt_o, 32'd0);
        rst_n_i = 1'b1;
        step();
        check("ready_after_rst", 32'(info_ready_o), 32'd1);

        // Default routing with 3-cycle latency
        cnt_en_i = 1'b1;
        send(16'd64, '0, 3'b000);
        check("lat_c1", 32'(dir_valid_o), 32'd0);
        step();
        check("lat_c2", 32'(dir_valid_o), 32'd0);
        step();
        check("lat_c3", 32'(dir_valid_o), 32'd1);
        check("cnt_dir", 32'(dir_o), 32'(RX_DIR_CNT));
        check("cnt_size", 32'(dir_pkt_size_o), 32'd64);
        step();
        check("popped", 32'(dir_valid_o), 32'd0);
        cnt_en_i = 1'b0;
        got.delete();
        send(16'd65, '0, 3'b000);
        wait_q(1, "nocnt_n");
        check_entry(0, RX_DIR_DROP, 16'd65, "nocnt_drop");
        check("drop_cnt_a", drop_cnt_o, sx(1));

        // Error drop wins over a trap
        stat_clr_i = 1'b1; step(); stat_clr_i = 1'b0;
        check("clr_drop", drop_cnt_o, 32'd0);
        drop_err_en_i = 3'b001; cpu_class_en_i = ARP; cnt_en_i = 1'b1;
        got.delete();
        send(16'd70, ARP, 3'b001);
        wait_q(1, "prio_n");
        check_entry(0, RX_DIR_DROP, 16'd70, "prio_drop");
        check("prio_drop_cnt", drop_cnt_o, sx(1));

        // Per-bit drop enables
        drop_err_en_i = 3'b110;
        got.delete();
        send(16'd71, '0, 3'b010);
        send(16'd72, '0, 3'b001);
        wait_q(2, "err_en_n");
        check_entry(0, RX_DIR_DROP, 16'd71, "runt_drop");
        check_entry(1, RX_DIR_CNT, 16'd72, "crc_masked");
        drop_err_en_i = 3'b000;

        // Token bucket: two ticks of 1500 capped at 3000, four 1000-byte traps
        cpu_rate_i = 20'd1500; cpu_bucket_max_i = 20'd3000;
        tick_once(); tick_once();
        got.delete();
        repeat (4) send(16'd1000, ARP, 3'b000);
        wait_q(4, "tok_n");
        check_entry(0, RX_DIR_CPU, 16'd1000, "tok0");
        check_entry(1, RX_DIR_CPU, 16'd1000, "tok1");
        check_entry(2, RX_DIR_CPU, 16'd1000, "tok2");
        check_entry(3, RX_DIR_DROP, 16'd1000, "tok3");
        check("tok_pol", cpu_policed_cnt_o, sx(1));
        check("tok_drop", drop_cnt_o, sx(3));

        // Tick in the consume cycle: 100 - 100 + 50 = 50 left
        cpu_rate_i = 20'd100; cpu_bucket_max_i = 20'd1000;
        tick_once();
        cpu_rate_i = 20'd50;
        got.delete();
        send(16'd100, ARP, 3'b000);
        tick_once();
        send(16'd50, ARP, 3'b000);
        send(16'd1, ARP, 3'b000);
        wait_q(3, "same_n");
        check_entry(0, RX_DIR_CPU, 16'd100, "same_cpu");
        check_entry(1, RX_DIR_CPU, 16'd50, "left50_cpu");
        check_entry(2, RX_DIR_DROP, 16'd1, "empty_drop");
        check("same_pol", cpu_policed_cnt_o, sx(2));
        check("same_drop", drop_cnt_o, sx(4));

        // Backpressure: 20 descriptors, consumer stalled
        cpu_class_en_i = '0; cnt_en_i = 1'b1; dir_ready_i = 1'b0;
        got.delete();
        sent = 0;
        repeat (30) begin
            info_i = '0;
            info_i.pkt_size = 16'(200 + sent);
            info_valid_i = 1'b1;
            acc = int'(info_ready_o);
            step();
            sent += acc;
        end
        check("bp_accepted", 32'(sent), 32'd8);
        check("bp_ready_low", 32'(info_ready_o), 32'd0);
        check("bp_head_size", 32'(dir_pkt_size_o), 32'd200);
        check("bp_no_pop", 32'(got.size()), 32'd0);
        dir_ready_i = 1'b1;
        acc = 0;
        while (sent < 20 && acc < 200) begin
            info_i.pkt_size = 16'(200 + sent);
            info_valid_i = 1'b1;
            if (info_ready_o) begin step(); sent++; end else step();
            acc++;
        end
        info_valid_i = 1'b0;
        wait_q(20, "bp_total");
        repeat (5) step();
        check("bp_no_dup", 32'(got.size()), 32'd20);
        for (int i = 0; i < 20; i++)
            check_entry(i, RX_DIR_CNT, 16'(200 + i), $sformatf("bp_order%0d", i));

        // Reset with entries queued and tokens loaded
        cpu_rate_i = 20'd500; cpu_bucket_max_i = 20'd1000;
        tick_once();
        dir_ready_i = 1'b0;
        repeat (5) send(16'd300, '0, 3'b000);
        repeat (4) step();
        check("mid_queued", 32'(dir_valid_o), 32'd1);
        rst_n_i = 1'b0;
        step();
        check("mid_valid", 32'(dir_valid_o), 32'd0);
        check("mid_pol", cpu_policed_cnt_o, 32'd0);
        check("mid_drop", drop_cnt_o, 32'd0);
        rst_n_i = 1'b1;
        step();
        check("mid_ready", 32'(info_ready_o), 32'd1);
        dir_ready_i = 1'b1;
        got.delete();
        cpu_class_en_i = ARP;
        send(16'd1, ARP, 3'b000);
        wait_q(1, "mid_n");
        repeat (5) step();
        check("mid_discarded", 32'(got.size()), 32'd1);
        check_entry(0, RX_DIR_DROP, 16'd1, "mid_tokens0");
        check("mid_pol1", cpu_policed_cnt_o, sx(1));
        stat_clr_i = 1'b1; step(); stat_clr_i = 1'b0;
        check("clr_pol", cpu_policed_cnt_o, 32'd0);
        check("clr_drop2", drop_cnt_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xge_rx_dir_arb.md
Name: xge_rx_dir_arb

Overview:
- Per-packet direction scheduler for the 10G RX path.
- Accepts one pkt_rx_info_t descriptor per received packet and applies drop, CPU-trap and count policy from configuration inputs.
- Polices CPU-bound traffic with a byte token bucket, then queues the resulting RX_DIR_* decision towards traf_engine through a valid/ready FIFO.
- Sits between the RX parser (descriptor producer) and traf_engine (direction consumer).

Parameters:
- FIFO_DEPTH, 8, decision FIFO entries; power of two, minimum 4.
- TOKEN_W, 20, token bucket width in bytes.

Ports:
- clk_i  in  1  RX core clock
- rst_n_i  in  1  synchronous reset, active low
- info_i  in  pkt_rx_info_t  packet descriptor
- info_valid_i  in  1  descriptor valid
- info_ready_o  out  1  block can accept a descriptor
- cpu_class_en_i  in  11  CPU trap enables: 0 oam, 1 telnet, 2 ssh, 3 arp, 4 icmp, 5 dhcp, 6 dns, 7 ptp, 8 twamp_control, 9 usercast, 10 nic_encaps
- drop_err_en_i  in  3  drop enables: 0 crc_err, 1 runt, 2 oversize
- cnt_en_i  in  1  route non-trapped good packets to RX_DIR_CNT
- cpu_tick_i  in  1  refill strobe
- cpu_rate_i  in  TOKEN_W  bytes added per tick
- cpu_bucket_max_i  in  TOKEN_W  bucket ceiling
- dir_o  out  2  RX_DIR_DROP / RX_DIR_CPU / RX_DIR_CNT
- dir_pkt_size_o  out  16  pkt_size of the head entry
- dir_valid_o  out  1  head entry valid
- dir_ready_i  in  1  consumer accepts the head entry
- stat_clr_i  in  1  clear statistics
- cpu_policed_cnt_o  out  32  CPU candidates dropped by the policer
- drop_cnt_o  out  32  total RX_DIR_DROP decisions

Behaviour:
- Reset: all outputs 0; FIFO empty; tokens 0; pipeline valids 0. Reset mid-operation discards every in-flight descriptor and FIFO entry.
- Handshake:
  - A descriptor is transferred when info_valid_i && info_ready_o.
  - info_ready_o = (FIFO free entries − pipeline occupancy) ≥ 1, registered. This makes FIFO overflow impossible.
- Stage 1 (classify), registered:
  - err = |(drop_err_en_i & {oversize, runt, crc_err}).
  - trap = |(cpu_class_en_i & class bits).
  - Result: err → DROP; else trap → CPU candidate; else cnt_en_i → CNT; else DROP.
- Stage 2 (police), registered:
  - CPU candidate with tokens ≥ pkt_size → CPU, and tokens −= pkt_size.
  - CPU candidate with tokens < pkt_size → DROP, and the policed counter increments.
- Token update per cycle:
  - t' = tokens − consumed (consumed = 0 or pkt_size).
  - If cpu_tick_i, t' = min(t' + cpu_rate_i, cpu_bucket_max_i).
  - Tick and consume in the same cycle: the consume check uses the pre-tick value; both then apply.
  - The addition is done in TOKEN_W+1 bits before the clamp, so there is no wrap.
  - If cpu_bucket_max_i is lowered below tokens, tokens clamp on the next tick only.
- FIFO write: at stage 2 output. Registered output: dir_valid_o asserts 3 cycles after acceptance when the FIFO is empty. Throughput is 1 descriptor per cycle.
- Pop: on dir_valid_o && dir_ready_i. Simultaneous push and pop when full cannot occur; simultaneous push and pop when empty yields the new entry the next cycle.
- While dir_valid_o && !dir_ready_i, dir_o and dir_pkt_size_o hold stable.
- Config inputs are sampled at stage 1/2 per packet. Changes affect only later packets.

Optional Feature:
- XGE_RX_DIR_STATS_EN defined:
  - cpu_policed_cnt_o and drop_cnt_o are 32-bit wrapping counters.
  - stat_clr_i has priority over an increment in the same cycle.
- XGE_RX_DIR_STATS_EN undefined: both outputs tie to 0, stat_clr_i is ignored, and no counter flops are built.

Decomposition:
- Package xge_rx holds pkt_rx_info_t and RX_DIR_*.
- Add to xge_rx:
  - CPU_CLS_* bit index constants 0..10, plus CPU_CLS_NUM = 11.
  - DROP_ERR_* index constants.
  - typedef rx_dir_t (2-bit).
- Sub-module xge_rx_cpu_policer: token bucket with inputs tick/rate/max/req/size and output grant.
- FIFO uses the existing common sync FIFO.

Test Plan:
- Policy priority: crc_err=1 with arp=1, drop_err_en_i=3'b001, cpu_class_en_i[3]=1 → dir_o=RX_DIR_DROP, drop_cnt_o=1.
- Trap with tokens:
  - Setup: cpu_bucket_max_i=3000, cpu_rate_i=1500, 2 ticks; arp packets of size 1000 ×4.
  - Expect: CPU, CPU, CPU, DROP; cpu_policed_cnt_o=1.
- Same-cycle tick and consume:
  - Setup: tokens=100, size 100 packet, tick with rate 50, max 1000.
  - Expect: CPU; tokens=50.
- Backpressure:
  - Setup: dir_ready_i=0, 20 back-to-back descriptors with FIFO_DEPTH=8.
  - Expect: info_ready_o deasserts; 8 entries held in order; release → all 8 drain, then the rest, no loss or duplication.
- Default routing: cnt_en_i=1, no trap bits → RX_DIR_CNT; cnt_en_i=0 → RX_DIR_DROP; latency exactly 3 cycles on an empty FIFO.
- Reset mid-stream: rst_n_i low while 5 entries are queued → dir_valid_o=0 next cycle, counters and tokens 0; stat_clr_i clears counters.
